reg_writeback_unit: RTL

REG_WRITEBACK_UNIT -- requirements
Module: reg_writeback_unit

---
 rtl/reg_writeback_unit_if.sv | 23 ++
 rtl/reg_writeback_unit.sv | 136 +++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit_if.sv
// rtl/reg_writeback_unit_if.sv - issue/writeback channel bundle for reg_writeback_unit
interface reg_writeback_unit_if #(
  parameter int ID_W  = 5,
  parameter int VAL_W = 64
);
  logic             issue_valid;
  logic [ID_W-1:0]  issue_dst_id;
  logic             wb_valid;
  logic             wb_ready;
  logic [ID_W-1:0]  wb_dst_id;
  logic [VAL_W-1:0] wb_val;
  logic             wb_hold;

  modport master (
    output issue_valid, issue_dst_id, wb_valid, wb_dst_id, wb_val, wb_hold,
    input  wb_ready
  );

  modport slave (
    input  issue_valid, issue_dst_id, wb_valid, wb_dst_id, wb_val, wb_hold,
    output wb_ready
  );
endinterface

// File: rtl/reg_writeback_unit.sv
// rtl/reg_writeback_unit.sv - in-order writeback buffer, register file and scoreboard
// Optional result/issue consistency checker enabled by defining WB_ERR_CHECK_EN.
module reg_writeback_unit #(
  parameter int REG_FILE_SIZE = 16,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  reg_writeback_unit_if.slave bus,
  output logic [63:0]         reg_file [REG_FILE_SIZE],
  output logic [REG_FILE_SIZE-1:0] sb,
  output logic                wb_idle
`ifdef WB_ERR_CHECK_EN
  ,
  output logic                wb_err
`endif
);

  typedef logic [4:0]  reg_id_t;
  typedef logic [63:0] reg_val_t;

  localparam int NUM_W = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Ids at or above REG_FILE_SIZE (rnil, rip, rimm, rv0, rv8, rsyscall) have no file slot.
  function automatic logic reg_in_file(input reg_id_t id);
    return int'(id) < REG_FILE_SIZE;
  endfunction

  function automatic logic [NUM_W-1:0] reg_num(input reg_id_t id);
    return NUM_W'(id);
  endfunction

  reg_id_t            fifo_id  [FIFO_DEPTH];
  reg_val_t           fifo_val [FIFO_DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               ready;
  logic               accept;
  logic               commit;
  logic               commit_file;
  logic               issue_file;
  reg_id_t            head_id;
  reg_val_t           head_val;
  logic [REG_FILE_SIZE-1:0] sb_next;

  assign ready        = (count != CNT_W'(FIFO_DEPTH));
  assign bus.wb_ready = ready;
  assign wb_idle      = (count == '0) && (sb == '0);

  always_comb begin
    accept      = bus.wb_valid && ready;
    commit      = (count != '0) && !bus.wb_hold;
    head_id     = fifo_id[head];
    head_val    = fifo_val[head];
    commit_file = commit && reg_in_file(head_id);
    issue_file  = bus.issue_valid && reg_in_file(bus.issue_dst_id);
    count_next  = count;
    if (accept && !commit) begin
      count_next = count + 1'b1;
    end else if (!accept && commit) begin
      count_next = count - 1'b1;
    end
    // Issue set is applied after commit clear so a fresh producer keeps the bit busy.
    sb_next = sb;
    if (commit_file) begin
      sb_next[reg_num(head_id)] = 1'b0;
    end
    if (issue_file) begin
      sb_next[reg_num(bus.issue_dst_id)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      fifo_id[tail]  <= bus.wb_dst_id;
      fifo_val[tail] <= bus.wb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      sb    <= '0;
      for (int i = 0; i < REG_FILE_SIZE; i++) begin
        reg_file[i] <= '0;
      end
    end else begin
      if (accept) begin
        tail <= tail + 1'b1;
      end
      if (commit) begin
        head <= head + 1'b1;
      end
      count <= count_next;
      sb    <= sb_next;
      if (commit_file) begin
        reg_file[reg_num(head_id)] <= head_val;
      end
    end
  end

`ifdef WB_ERR_CHECK_EN
  logic err_commit;
  logic err_issue;

  // An issue to a bit being cleared on this same edge is a legitimate re-allocation.
  always_comb begin
    err_commit = commit_file && !sb[reg_num(head_id)];
    err_issue  = issue_file && sb[reg_num(bus.issue_dst_id)] &&
                 !(commit_file && (reg_num(head_id) == reg_num(bus.issue_dst_id)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_err <= 1'b0;
    end else begin
      if (err_commit || err_issue) begin
        wb_err <= 1'b1;
      end
      if (err_commit) begin
        $display("ERROR: reg_writeback_unit commit to non-busy register id %0d", head_id);
      end
      if (err_issue) begin
        $display("ERROR: reg_writeback_unit issue to busy register id %0d", bus.issue_dst_id);
      end
    end
  end
`endif

endmodule
